uart_tx_fifo: RTL and testbench

//  Transmit-side feeder for the UART core. Buffers bytes written by the CPU/bus

---
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that paces launches into a UART core which has
// no ready/busy output of its own.
//
// Ports:
//   clk, resetn    clock and asynchronous active-low reset
//   wr_en, wr_data push one byte; dropped while full
//   flush          synchronous clear of buffered bytes
//   full, empty    FIFO status, decoded from count
//   count          bytes currently buffered (ADDR_W+1 bits)
//   overflow       1-cycle pulse after a write was dropped
//   tx_busy        a byte is being sent or the frame gap is running
//   uart_send_en   registered 1-cycle launch pulse to the UART
//   uart_din       registered byte to the UART, held between launches
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_busy,
    output logic              uart_send_en,
    output logic [7:0]        uart_din
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int BPS_CNT    = CLK_FREQ / UART_BPS;
    localparam int GAP_CYCLES = 10 * BPS_CNT + 8;
    localparam int GAP_BITS   = $clog2(GAP_CYCLES + 1);
    localparam int WAIT_W     = (GAP_BITS > 16) ? GAP_BITS : 16;

    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              send_en_q, send_en_d;
    logic [7:0]        din_q, din_d;

    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // flush wins over both a push and a launch in the same cycle
    assign push = wr_en && !full && !flush;
    assign pop  = (state_q == S_IDLE) && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = wr_en && full && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // launch, then hold off for one full frame plus margin
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        send_en_d  = 1'b0;
        din_d      = din_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    din_d     = mem_q[rd_ptr_q];
                    send_en_d = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            send_en_q  <= 1'b0;
            din_q      <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            send_en_q  <= send_en_d;
            din_q      <= din_d;
        end
    end

    assign count        = count_q;
    assign overflow     = ovf_q;
    assign tx_busy      = (state_q != S_IDLE);
    assign uart_send_en = send_en_q;
    assign uart_din     = din_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table, corner sequences and random traffic
// for uart_tx_fifo, checked against a queue/timer reference model.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int GAP      = 10 * (CLK_FREQ / UART_BPS) + 8;
    localparam int PERIOD   = GAP + 2;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            flush = 1'b0;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_busy;
    logic            uart_send_en;
    logic [7:0]      uart_din;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .tx_busy     (tx_busy),
        .uart_send_en(uart_send_en),
        .uart_din    (uart_din)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model: byte queue plus cycles left before next launch
    logic [7:0] q[$];
    int         busy_left;
    logic       m_send;
    logic       m_ovf;
    logic [7:0] m_din;

    int         pulse_cyc[$];
    logic [7:0] pulse_byte[$];
    int         busy_cycles;
    int         ovf_seen;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       fl;
        int         e_count;
        logic       e_send;
        logic [7:0] e_din;
        logic       e_busy;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic model_reset();
        q.delete();
        busy_left = 0;
        m_send    = 1'b0;
        m_ovf     = 1'b0;
        m_din     = 8'h00;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d,
                              input logic f);
        bit full_pre;
        bit launch;
        full_pre = (q.size() == DEPTH);
        launch   = (busy_left == 0) && (q.size() != 0) && !f;
        m_send   = launch;
        m_ovf    = w && full_pre && !f;
        if (launch) begin
            m_din     = q.pop_front();
            busy_left = GAP + 1;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (f) begin
            q.delete();
        end else if (w && !full_pre) begin
            q.push_back(d);
        end
    endtask

    task automatic check(input string name);
        logic [31:0] act;
        logic [31:0] exp;
        act = {6'd0, count, full, empty, overflow, tx_busy,
               uart_send_en, uart_din, 8'd0};
        exp = {6'd0, 5'(q.size()), q.size() == DEPTH, q.size() == 0,
               m_ovf, busy_left != 0, m_send, m_din, 8'd0};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_int(input string name, input int act,
                              input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic f, input string name);
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        flush   = f;
        @(posedge clk);
        model_edge(w, d, f);
        cyc++;
        #1;
        if (uart_send_en === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_byte.push_back(uart_din);
        end
        if (tx_busy === 1'b1) busy_cycles++;
        if (overflow === 1'b1) ovf_seen++;
        check(name);
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, name);
    endtask

    task automatic clear_logs();
        pulse_cyc.delete();
        pulse_byte.delete();
        busy_cycles = 0;
        ovf_seen    = 0;
    endtask

    // asserts reset between edges so the async path is what gets checked
    task automatic apply_reset(input string name);
        @(negedge clk);
        wr_en  = 1'b0;
        flush  = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check(name);
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
    endtask

    initial begin
        int start;
        int w_div;
        model_reset();
        clear_logs();

        // directed table
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h33, 1'b1, 0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'h44, 1'b0, 1, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hA5, 1'b1, 1'b0};

        apply_reset("reset0");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].d;
            flush   = tbl[i].fl;
            @(posedge clk);
            #1;
            vectors++;
            if (count !== 5'(tbl[i].e_count) ||
                uart_send_en !== tbl[i].e_send ||
                uart_din !== tbl[i].e_din ||
                tx_busy !== tbl[i].e_busy ||
                overflow !== tbl[i].e_ovf) begin
                miscompares++;
                $display("FAIL table[%0d] act=%0d/%b/%h/%b/%b exp=%0d/%b/%h/%b/%b",
                         i, count, uart_send_en, uart_din, tx_busy,
                         overflow, tbl[i].e_count, tbl[i].e_send,
                         tbl[i].e_din, tbl[i].e_busy, tbl[i].e_ovf);
            end
        end

        // single byte: latency and busy window
        apply_reset("reset1");
        step(1'b1, 8'hA5, 1'b0, "single_wr");
        start = cyc;
        idle(130, "single_idle");
        expect_int("single_pulses", pulse_cyc.size(), 1);
        if (pulse_cyc.size() >= 1) begin
            expect_int("single_latency", pulse_cyc[0] - start, 1);
            expect_int("single_byte", int'(pulse_byte[0]), 'hA5);
        end
        expect_int("single_busy", busy_cycles, GAP + 1);

        // burst: spacing and order
        apply_reset("reset2");
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, "burst_wr");
        idle(4 * PERIOD + 20, "burst_idle");
        expect_int("burst_pulses", pulse_cyc.size(), 4);
        if (pulse_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++)
                expect_int("burst_byte", int'(pulse_byte[i]), i + 1);
            for (int i = 1; i < 4; i++)
                expect_int("burst_gap", pulse_cyc[i] - pulse_cyc[i-1],
                           PERIOD);
        end

        // overflow: 18 writes, first launches, the 18th is dropped
        apply_reset("reset3");
        for (int i = 0; i < 18; i++)
            step(1'b1, 8'h80 + 8'(i), 1'b0, "ovf_wr");
        expect_int("ovf_count", int'(count), DEPTH);
        expect_int("ovf_full", int'(full), 1);
        expect_int("ovf_pulses", ovf_seen, 1);
        idle(DEPTH * PERIOD + 20, "ovf_drain");
        expect_int("ovf_launches", pulse_byte.size(), 17);
        for (int i = 0; i < pulse_byte.size(); i++)
            if (pulse_byte[i] == 8'h91)
                expect_int("ovf_dropped_seen", i, -1);

        // continuous writes across the launch edge while full;
        // pointers here already sit at 1 so they wrap 15->0
        clear_logs();
        for (int i = 0; i < 2 * PERIOD; i++)
            step(1'b1, 8'h20 + 8'(i), 1'b0, "wrap_wr");
        idle((DEPTH + 1) * PERIOD + 20, "wrap_drain");
        expect_int("wrap_empty", int'(empty), 1);

        // flush during WAIT of the first byte
        apply_reset("reset5");
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, "fl_wr");
        idle(20, "fl_wait");
        step(1'b0, 8'h00, 1'b1, "fl_flush");
        idle(3 * PERIOD, "fl_idle");
        expect_int("fl_pulses", pulse_cyc.size(), 1);
        expect_int("fl_count", int'(count), 0);
        expect_int("fl_empty", int'(empty), 1);

        // reset in the middle of WAIT, then relaunch
        apply_reset("reset6");
        step(1'b1, 8'h5A, 1'b0, "rst_wr");
        idle(30, "rst_wait");
        apply_reset("rst_mid_wait");
        step(1'b1, 8'h6B, 1'b0, "rst_wr2");
        idle(2, "rst_relaunch");
        expect_int("rst_pulses", pulse_cyc.size(), 1);

        // random traffic
        apply_reset("reset7");
        for (int i = 0; i < 3000; i++) begin
            w_div = (i < 1500) ? 4 : 150;
            step(($urandom % w_div) == 0, 8'($urandom),
                 ($urandom % 300) == 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
